// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types and constants for the front-end hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        LSTALL = 1'b1
    } state_t;

    localparam int c_GR0     = 0;
    localparam int c_LSC_MIN = 1;
    localparam int c_LSC_MAX = 3;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Purpose  : Combinational compare of ID sources against the EX-stage load target.
// Revision : 1.0 - initial release
// ============================================================================
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] ID_RA,
    input  logic [REG_W-1:0] ID_RB,
    input  logic             ID_UseRA,
    input  logic             ID_UseRB,
    input  logic             EX_Load,
    input  logic             EX_RFE,
    input  logic [REG_W-1:0] EX_RD,
    output logic             Hazard
);

    logic w_ex_writes;
    logic w_match_ra;
    logic w_match_rb;

    // GR0 is hardwired to zero, so a load targeting it never creates a dependency
    assign w_ex_writes = EX_Load & EX_RFE & (EX_RD != REG_W'(c_GR0));
    assign w_match_ra  = ID_UseRA & (ID_RA == EX_RD);
    assign w_match_rb  = ID_UseRB & (ID_RB == EX_RD);
    assign Hazard      = w_ex_writes & (w_match_ra | w_match_rb);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : PC / IF-ID load enables, flush and bubble select for load-use
//            stalls, memory freezes and nullified delay slots.
//            Optional stall statistics enabled by defining HAZ_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W             = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] ID_RA,
    input  logic [REG_W-1:0] ID_RB,
    input  logic             ID_UseRA,
    input  logic             ID_UseRB,
    input  logic             EX_Load,
    input  logic             EX_RFE,
    input  logic [REG_W-1:0] EX_RD,
    input  logic             ID_BranchTaken,
    input  logic             ID_Nullify,
    input  logic             Mem_Busy,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             IF_ID_Reset,
    output logic             CU_NOP,
    output logic             Pipe_Freeze,
    output logic [CNT_W-1:0] Stall_Count
);

    generate
        if (LOAD_STALL_CYCLES < c_LSC_MIN || LOAD_STALL_CYCLES > c_LSC_MAX) begin : g_bad_lsc
            $error("hazard_ctrl: LOAD_STALL_CYCLES must be in 1..3");
        end
    endgenerate

    // The hazard cycle itself is the first bubble, so LSTALL covers the rest
    localparam logic [1:0] c_RELOAD = (LOAD_STALL_CYCLES > 1) ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_cnt;
    logic [1:0] w_next_cnt;
    logic       w_hazard;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .ID_RA    (ID_RA),
        .ID_RB    (ID_RB),
        .ID_UseRA (ID_UseRA),
        .ID_UseRB (ID_UseRB),
        .EX_Load  (EX_Load),
        .EX_RFE   (EX_RFE),
        .EX_RD    (EX_RD),
        .Hazard   (w_hazard)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        PC_LE        = 1'b1;
        IF_ID_LE     = 1'b1;
        IF_ID_Reset  = 1'b0;
        CU_NOP       = 1'b0;
        Pipe_Freeze  = 1'b0;

        if (Reset) begin
            PC_LE        = 1'b0;
            IF_ID_LE     = 1'b0;
            IF_ID_Reset  = 1'b1;
            CU_NOP       = 1'b1;
            w_next_state = RUN;
            w_next_cnt   = 2'd0;
        end else if (Mem_Busy) begin
            // Freeze everything; a stall in progress resumes exactly where it was
            PC_LE       = 1'b0;
            IF_ID_LE    = 1'b0;
            Pipe_Freeze = 1'b1;
        end else if (r_state == LSTALL) begin
            PC_LE    = 1'b0;
            IF_ID_LE = 1'b0;
            CU_NOP   = 1'b1;
            if (r_cnt == 2'd0) begin
                w_next_state = RUN;
            end else begin
                w_next_cnt = r_cnt - 2'd1;
            end
        end else if (w_hazard) begin
            PC_LE    = 1'b0;
            IF_ID_LE = 1'b0;
            CU_NOP   = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                w_next_state = LSTALL;
                w_next_cnt   = c_RELOAD;
            end
        end else if (ID_BranchTaken && ID_Nullify) begin
            IF_ID_Reset = 1'b1;
        end
    end

`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_stall_cnt <= '0;
        end else if (!PC_LE && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign Stall_Count = r_stall_cnt;
`else
    assign Stall_Count = '0;
`endif

endmodule
`default_nettype wire
